// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Purpose  : Sequences one ALU operation per valid/ready request. The operation
//            runs on the accumulator and the request operand. The registered
//            result is presented on the shared tri-state bus until the
//            consumer takes it.
// Options  : ALU_SEQ_DIVZERO_EN - when defined, a divide by zero is trapped
//            and raises err.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_op,
   input  logic [3:0] req_b,
   input  logic       req_load,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [3:0] alu_sel,
   input  logic [7:0] alu_out,
   input  logic       alu_cout,
   output logic [3:0] acc,
   output logic [7:0] res,
   output logic       res_valid,
   input  logic       res_ready,
   output logic       bus_en,
   output logic       carry,
   output logic       err
);

   localparam logic [3:0] c_OP_ADD = 4'b0000;
   localparam logic [3:0] c_OP_DIV = 4'b0011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_acc;
   logic [3:0] r_op;
   logic [3:0] r_b;
   logic [7:0] r_res;
   logic       r_carry;
   logic       w_accept_op;
   logic       w_accept_load;
   logic       w_div_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_accept_op   = 1'b0;
      w_accept_load = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_load) begin
                  w_accept_load = 1'b1;
               end else begin
                  w_accept_op = 1'b1;
                  w_state_nxt = ST_EXEC;
               end
            end
         end
         ST_EXEC: w_state_nxt = ST_OUT;
         ST_OUT: begin
            if (res_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

`ifdef ALU_SEQ_DIVZERO_EN
   logic r_err;

   assign w_div_zero = (r_op == c_OP_DIV) && (r_b == 4'd0);

   // Registered so the pulse lines up with the first OUT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else begin
         r_err <= (r_state == ST_EXEC) && w_div_zero;
      end
   end

   assign err = r_err;
`else
   assign w_div_zero = 1'b0;
   assign err        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc   <= 4'd0;
         r_op    <= 4'd0;
         r_b     <= 4'd0;
         r_res   <= 8'h00;
         r_carry <= 1'b0;
      end else begin
         if (w_accept_load) begin
            r_acc <= req_b;
         end
         if (w_accept_op) begin
            r_op <= req_op;
            r_b  <= req_b;
         end
         if (r_state == ST_EXEC) begin
            if (w_div_zero) begin
               r_res   <= 8'h00;
               r_carry <= 1'b0;
            end else begin
               // Only the low nibble fits back into the accumulator.
               r_res   <= alu_out;
               r_acc   <= alu_out[3:0];
               r_carry <= (r_op == c_OP_ADD) ? alu_cout : 1'b0;
            end
         end
      end
   end

   assign req_ready = (r_state == ST_IDLE);
   assign res_valid = (r_state == ST_OUT);
   assign bus_en    = (r_state == ST_OUT);
   assign alu_a     = r_acc;
   assign alu_b     = r_b;
   assign alu_sel   = r_op;
   assign acc       = r_acc;
   assign res       = r_res;
   assign carry     = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Purpose  : Randomized and directed bench for alu_seq_ctrl with an ALU model
//            and an accumulator-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_op;
   logic [3:0] req_b;
   logic       req_load;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [3:0] alu_sel;
   logic [7:0] alu_out;
   logic       alu_cout;
   logic [3:0] acc;
   logic [7:0] res;
   logic       res_valid;
   logic       res_ready;
   logic       bus_en;
   logic       carry;
   logic       err;

   int n_total = 0;
   int n_bad   = 0;

   logic [3:0] m_acc;
   logic [7:0] m_res;
   logic       m_carry;
   logic       m_err;

   alu_seq_ctrl u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_b     (req_b),
      .req_load  (req_load),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_out   (alu_out),
      .alu_cout  (alu_cout),
      .acc       (acc),
      .res       (res),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .bus_en    (bus_en),
      .carry     (carry),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 4-bit ALU behaviour: returns {cout, result}.
   function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [3:0] a,
                                        input logic [3:0] b);
      logic [7:0] ea, eb, o;
      logic       c;
      ea = {4'd0, a};
      eb = {4'd0, b};
      o  = 8'h00;
      c  = 1'b0;
      case (op)
         4'h0: begin o = ea + eb; c = o[4]; end
         4'h1: begin o = ea - eb; c = (a < b); end
         4'h2: begin o = ea * eb; c = |o[7:4]; end
         4'h3: o = (b == 4'd0) ? 8'hFF : ea / eb;
         4'h4: o = ea << 1;
         4'h5: o = ea >> 1;
         4'h6: o = {4'd0, a[2:0], a[3]};
         4'h7: o = {4'd0, a[0], a[3:1]};
         4'h8: o = ea & eb;
         4'h9: o = ea | eb;
         4'hA: o = ea ^ eb;
         4'hB: o = {4'd0, ~(a | b)};
         4'hC: o = {4'd0, ~(a & b)};
         4'hD: o = {4'd0, ~(a ^ b)};
         4'hE: o = (a > b) ? 8'h01 : 8'h00;
         default: o = (a == b) ? 8'h01 : 8'h00;
      endcase
      return {c, o};
   endfunction

   logic [8:0] w_alu_res;
   always_comb w_alu_res = alu_f(alu_sel, alu_a, alu_b);
   assign alu_out  = w_alu_res[7:0];
   assign alu_cout = w_alu_res[8];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_op(input logic [3:0] op, input logic [3:0] b);
      logic [8:0] r;
      m_err = 1'b0;
`ifdef ALU_SEQ_DIVZERO_EN
      if (op == 4'h3 && b == 4'd0) begin
         m_res   = 8'h00;
         m_carry = 1'b0;
         m_err   = 1'b1;
         return;
      end
`endif
      r       = alu_f(op, m_acc, b);
      m_res   = r[7:0];
      m_acc   = r[3:0];
      m_carry = (op == 4'h0) ? r[8] : 1'b0;
   endtask

   task automatic model_reset();
      m_acc   = 4'd0;
      m_res   = 8'h00;
      m_carry = 1'b0;
      m_err   = 1'b0;
   endtask

   // Issue one request from IDLE and follow it back to IDLE.
   task automatic run_op(input logic ld, input logic [3:0] op, input logic [3:0] b,
                         input int hold);
      int waited = 0;
      while (!req_ready && waited < 8) begin
         @(posedge clk); #1;
         waited++;
      end
      check("idle_ready", req_ready, 1);
      req_valid = 1'b1;
      req_load  = ld;
      req_op    = op;
      req_b     = b;
      res_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (ld) begin
         m_acc     = b;
         req_valid = 1'b0;
         check("load_acc", acc, m_acc);
         check("load_ready", req_ready, 1);
         check("load_res", res, m_res);
      end else begin
         model_op(op, b);
         req_op   = 4'($urandom);
         req_b    = 4'($urandom);
         req_load = 1'($urandom);
         check("exec_ready", req_ready, 0);
         check("exec_valid", res_valid, 0);
         check("exec_err", err, 0);
         res_ready = (hold == 0);
         @(posedge clk); #1;
         check("out_valid", res_valid, 1);
         check("out_bus", bus_en, 1);
         check("out_ready", req_ready, 0);
         check("out_res", res, m_res);
         check("out_acc", acc, m_acc);
         check("out_carry", carry, m_carry);
         check("out_err", err, m_err);
         for (int i = 1; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", res_valid, 1);
            check("hold_bus", bus_en, 1);
            check("hold_ready", req_ready, 0);
            check("hold_res", res, m_res);
            check("hold_acc", acc, m_acc);
            check("hold_err", err, 0);
         end
         res_ready = 1'b1;
         req_valid = 1'b0;
         req_load  = 1'b0;
         @(posedge clk); #1;
         check("back_idle_valid", res_valid, 0);
         check("back_idle_ready", req_ready, 1);
         check("back_idle_res", res, m_res);
         check("back_idle_acc", acc, m_acc);
      end
   endtask

   initial begin
      int res_cycle[$];
      int cyc;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op    = 4'd0;
      req_b     = 4'd0;
      req_load  = 1'b0;
      res_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", req_ready, 1);
      check("rst_valid", res_valid, 0);
      check("rst_bus", bus_en, 0);
      check("rst_acc", acc, 0);
      check("rst_res", res, 0);
      check("rst_carry", carry, 0);
      check("rst_err", err, 0);
      check("rst_alu_sel", alu_sel, 0);
      check("rst_alu_b", alu_b, 0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // Add with carry, then subtract.
      run_op(1'b1, 4'h0, 4'h5, 0);
      run_op(1'b0, 4'h0, 4'hC, 1);
      check("add_res", res, 8'h11);
      check("add_acc", acc, 4'h1);
      check("add_carry", carry, 1);
      run_op(1'b0, 4'h1, 4'h1, 0);
      check("sub_acc", acc, 4'h0);
      check("sub_carry", carry, 0);

      // Multiply with backpressure.
      run_op(1'b1, 4'h0, 4'h3, 0);
      run_op(1'b0, 4'h2, 4'h5, 5);
      check("mul_res", res, 8'h0F);

      // Compares.
      run_op(1'b1, 4'h0, 4'h7, 0);
      run_op(1'b0, 4'hE, 4'h3, 0);
      check("gt_res", res, 8'h01);
      check("gt_acc", acc, 4'h1);
      run_op(1'b0, 4'hF, 4'h2, 2);
      check("eq_res", res, 8'h00);
      check("eq_acc", acc, 4'h0);

      // Divide by zero.
      run_op(1'b1, 4'h0, 4'h9, 0);
      run_op(1'b0, 4'h3, 4'h0, 0);
`ifdef ALU_SEQ_DIVZERO_EN
      check("dz_acc", acc, 4'h9);
      check("dz_res", res, 8'h00);
`else
      check("dz_acc", acc, 4'hF);
      check("dz_res", res, 8'hFF);
`endif

      // Back-to-back adds with req_valid held high.
      run_op(1'b1, 4'h0, 4'h0, 0);
      req_valid = 1'b1;
      req_load  = 1'b0;
      req_op    = 4'h0;
      req_b     = 4'h1;
      res_ready = 1'b1;
      cyc = 0;
      while (res_cycle.size() < 4 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (res_valid) begin
            res_cycle.push_back(cyc);
            model_op(4'h0, 4'h1);
            check("b2b_res", res, m_res);
            if (res_cycle.size() == 4) req_valid = 1'b0;
         end
      end
      check("b2b_count", res_cycle.size(), 4);
      for (int i = 1; i < res_cycle.size(); i++) begin
         check("b2b_spacing", res_cycle[i] - res_cycle[i-1], 3);
      end
      @(posedge clk); #1;
      check("b2b_acc", acc, 4'h4);
      check("b2b_idle", req_ready, 1);

      // Randomized mix.
      for (int n = 0; n < 40; n++) begin
         logic       ld;
         logic [3:0] op, b;
         ld = ($urandom_range(0, 3) == 0);
         op = 4'($urandom);
         b  = 4'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            op = 4'h3;
            b  = 4'h0;
         end
         run_op(ld, op, b, $urandom_range(0, 3));
      end

      // Asynchronous reset while the result is on the bus.
      run_op(1'b1, 4'h0, 4'h7, 0);
      req_valid = 1'b1;
      req_load  = 1'b0;
      req_op    = 4'h0;
      req_b     = 4'hA;
      res_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_bus", bus_en, 1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_bus", bus_en, 0);
      check("arst_valid", res_valid, 0);
      check("arst_acc", acc, m_acc);
      check("arst_res", res, m_res);
      check("arst_carry", carry, m_carry);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check("arst_ready", req_ready, 1);
      check("arst_hold_acc", acc, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencer for the 4-bit ALU, accumulator and tri-state result buffer. Accepts one operation at a time over a valid/ready handshake. Drives the ALU from an internal 4-bit accumulator and the request operand, and registers the 8-bit result. Presents the result on the shared bus through the tri-state buffer enable until the consumer takes it.

## Interface
- No parameters; the data widths are fixed (4-bit operands, 8-bit result, 4-bit opcode).
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_op  in  4  ALU opcode, using the ALU_Sel encoding: 0000 add … 1111 equal.
- req_b  in  4  operand B, or the load value when req_load=1.
- req_load  in  1  load req_b into the accumulator; the ALU is not used.
- alu_a  out  4  ALU operand A; always equals acc.
- alu_b  out  4  ALU operand B; registered copy of req_b.
- alu_sel  out  4  ALU opcode; registered copy of req_op.
- alu_out  in  8  ALU result (combinational).
- alu_cout  in  1  ALU carry out.
- acc  out  4  accumulator value.
- res  out  8  registered result.
- res_valid  out  1  res holds an unconsumed result.
- res_ready  in  1  consumer takes res.
- bus_en  out  1  tri-state buffer enable; equals res_valid.
- carry  out  1  carry of the last completed add; 0 after any other op.
- err  out  1  one-cycle pulse on divide-by-zero (see Configuration).

## Operation
- States: IDLE, EXEC, OUT.
- IDLE
  - req_ready=1.
  - On req_valid & req_load: acc <= req_b; stay in IDLE; res and carry unchanged.
  - On req_valid & !req_load: op_reg <= req_op, b_reg <= req_b; go to EXEC.
- EXEC
  - req_ready=0; alu_a/alu_b/alu_sel are stable for the whole cycle.
  - At the clock edge: res <= alu_out; acc <= alu_out[3:0]; carry <= (op_reg==0000) ? alu_cout : 0; go to OUT.
- OUT
  - res_valid=1, bus_en=1; res and acc are held.
  - When res_ready=1: go to IDLE and drop res_valid the next cycle.
  - When res_ready=0: hold indefinitely.
- Width rules
  - Accumulator write-back is truncated to alu_out[3:0].
  - res keeps the full 8 bits; the upper nibble is visible only on res.
  - Compare ops write 0 or 1.
- Requests arriving outside IDLE are ignored (req_ready=0); the requester must hold req_valid.

## Timing
- Reset values: state=IDLE, acc=0, res=8'h00, carry=0, res_valid=0, bus_en=0, err=0, req_ready=1, op_reg=0, b_reg=0.
- Reset mid-operation (EXEC or OUT) aborts immediately and asynchronously: bus_en falls with rst_n, no write-back occurs, and the result is lost.
- Latency
  - ALU request accepted at edge T → EXEC in cycle T..T+1 → res_valid=1 from edge T+1.
  - Best-case throughput is one op per 3 cycles (IDLE, EXEC, OUT with res_ready already high).
- Load request: acc updates at the accepting edge; the next request can be accepted in the following cycle.
- res_ready high in the same cycle res_valid rises completes the transfer at the next edge.
- res_ready is don't-care outside OUT.
- err pulses for exactly the EXEC→OUT edge cycle, i.e. it is high during the first OUT cycle.

## Configuration
- ALU_SEQ_DIVZERO_EN defined:
  - In EXEC, if op_reg==0011 and b_reg==0: res <= 8'h00, acc unchanged, carry <= 0, err=1 for one cycle; OUT is still entered so the consumer sees a completion.
- ALU_SEQ_DIVZERO_EN undefined:
  - No check; divide executes like any other op with the ALU output written back.
  - err tied to 0.

## Test plan
- Reset: assert rst_n=0 mid-OUT → bus_en, res_valid, acc, res, carry all 0 immediately; req_ready=1 after release.
- Load 4'h5, then add B=4'hC → res=8'h11, acc=4'h1, carry=1, res_valid two edges after acceptance; a following sub B=1 gives carry=0, acc=4'h0.
- Backpressure: hold res_ready=0 for 5 cycles after a multiply (acc=3, B=5) → res=8'h0F held with bus_en=1 throughout; req_valid ignored (req_ready=0); release → IDLE one edge later.
- Compare: acc=7, greater op (1110) with B=3 → res=8'h01, acc=1; equal op (1111) with B=2 → res=8'h00, acc=0.
- Divide by zero with ALU_SEQ_DIVZERO_EN: acc=9, op 0011, B=0 → err=1 for one cycle, res=8'h00, acc stays 9. Without the macro, err stays 0.
- Back-to-back: req_valid held high with res_ready=1 across 4 adds of B=1 from acc=0 → acc=4, each result spaced exactly 3 cycles apart.
